// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
//   state_t    : converter FSM states
//   cnt_width  : bit-counter width needed to hold BIN_W
//   bcd_max    : largest value representable in a given number of BCD digits
//   bin_max    : largest value representable in a given number of binary bits
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned BIN_W_DEF  = 11;
  localparam int unsigned DIGITS_DEF = 4;
  localparam int unsigned CNT_W_DEF  = $clog2(BIN_W_DEF + 1);

  // Width of a down-counter that must hold the value bin_w.
  function automatic int unsigned cnt_width(input int unsigned bin_w);
    int unsigned w;
    w = $clog2(bin_w + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // 10**digits - 1, the overflow threshold.
  function automatic logic [63:0] bcd_max(input int unsigned digits);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  // 2**bin_w - 1, the largest binary operand.
  function automatic logic [63:0] bin_max(input int unsigned bin_w);
    return (bin_w >= 64) ? {64{1'b1}} : ((64'd1 << bin_w) - 64'd1);
  endfunction

endpackage

// File: rtl/bin2bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decade.
//   i_nib   : scratch BCD digit before the shift
//   o_nib_c : corrected digit (combinational)
module bin2bcd_digit_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib_c
);

  always_comb begin
    o_nib_c = i_nib;
    if (i_nib >= 4'd5) begin
      o_nib_c = i_nib + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Start/busy/done handshake; bcd/ovf/blank are registered and held between results.
// Optional leading-zero blanking is enabled by defining BIN2BCD_LZ_BLANK_EN;
// without it the blank port is tied to zero.
//   clk   : system clock, rising edge
//   rst   : synchronous reset, active-high
//   start : conversion request, honoured only in IDLE
//   bin   : binary operand, captured on the accepted start
//   busy  : high while operand bits are being shifted
//   done  : one-cycle pulse when bcd/ovf/blank are updated
//   bcd   : packed BCD result, digit 0 (units) in bcd[3:0]
//   ovf   : captured operand exceeded 10**DIGITS-1
//   blank : leading-zero mask, bit i set when digit i is blanked
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CNT_W   = cnt_width(BIN_W);
  localparam logic [63:0] BCD_MAX = bcd_max(DIGITS);
  // Overflow is only reachable when the operand range exceeds the digit range.
  localparam logic        OVF_ABLE = (bin_max(BIN_W) > BCD_MAX);

  state_t             r_state;
  state_t             w_state_next;

  logic [BIN_W-1:0]   r_sr;
  logic [BCD_W-1:0]   r_scr;
  logic [BCD_W-1:0]   w_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;

  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;

  logic               w_load;
  logic               w_shift;
  logic               w_commit;
  logic               w_busy_next;
  logic               w_ovf_next;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the last shift is the one taken with r_cnt == 1.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM decode into datapath controls.
  always_comb begin
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE:    w_load   = start;
      SHIFT:   w_shift  = 1'b1;
      DONE:    w_commit = 1'b1;
      default: ;
    endcase
    w_busy_next = (w_state_next == SHIFT);
  end

  assign w_ovf_next = OVF_ABLE && (64'(bin) > BCD_MAX);

  // Per-digit +3 correction ahead of every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin2bcd_digit_adj u_adj (
      .i_nib   (r_scr[4*g +: 4]),
      .o_nib_c (w_adj[4*g +: 4])
    );
  end

  // Shift datapath and result registers; bits leaving the top digit are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_commit;
      if (w_load) begin
        r_sr       <= bin;
        r_scr      <= '0;
        r_cnt      <= CNT_W'(BIN_W);
        r_ovf_pend <= w_ovf_next;
      end
      if (w_shift) begin
        r_scr <= {w_adj[BCD_W-2:0], r_sr[BIN_W-1]};
        r_sr  <= r_sr << 1;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_commit) begin
        r_bcd <= r_scr;
        r_ovf <= r_ovf_pend;
      end
    end
  end

`ifdef BIN2BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_zero_run;

  // Walk down from the top digit; blanking stops at the first nonzero digit.
  // The units digit is never blanked, and an overflowed result is shown in full.
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (r_scr[4*i +: 4] == 4'd0);
      w_blank[i] = w_zero_run;
    end
    if (r_ovf_pend) begin
      w_blank = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank <= '0;
    end else if (w_commit) begin
      r_blank <= w_blank;
    end
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule
